// File: rtl/hex_display_ctrl_if.sv
// rtl/hex_display_ctrl_if.sv - load/value/mode/blink inputs and busy/segment outputs of the display controller
interface hex_display_ctrl_if #(
    parameter int NDIGITS = 8
);
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [1:0]             mode;
    logic                   blink_en;
    logic                   busy;
    logic [7*NDIGITS-1:0]   HEX;

    modport master (
        output load, value, mode, blink_en,
        input  busy, HEX
    );

    modport slave (
        input  load, value, mode, blink_en,
        output busy, HEX
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - seven-segment controller: hex, blanked hex, double-dabble decimal, blink
module hex_display_ctrl #(
    parameter int NDIGITS   = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                CLOCK_50,
    input  logic                RST,
    hex_display_ctrl_if.slave   bus
);
    localparam int DATA_W = 4 * NDIGITS;
    localparam int BCD_W  = 4 * (NDIGITS + 2);
    localparam int HEX_W  = 7 * NDIGITS;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam int BLK_W  = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [6:0]       SEG_DASH = 7'b0111111;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  src_q, src_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HEX_W-1:0]   disp_q, disp_d;
    logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_step;
    logic [HEX_W-1:0]   hex_glyphs;
    logic [HEX_W-1:0]   lz_glyphs;
    logic [HEX_W-1:0]   dec_glyphs;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b0100111;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Blank every digit above the most significant nonzero nibble; digit 0 always shows.
    function automatic logic [HEX_W-1:0] blank_leading(input logic [DATA_W-1:0] nibs);
        logic             seen;
        logic [HEX_W-1:0] g;
        seen = 1'b0;
        g    = '1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            if (nibs[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
            if (seen) g[7*i +: 7] = glyph(nibs[4*i +: 4]);
        end
        return g;
    endfunction

    // Glyph images for each display mode, and one double-dabble step on the BCD register.
    always_comb begin
        hex_glyphs = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            hex_glyphs[7*i +: 7] = glyph(bus.value[4*i +: 4]);
        end
        lz_glyphs = blank_leading(bus.value);

        bcd_adj = bcd_q;
        for (int j = 0; j < NDIGITS + 2; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
        end
        bcd_step = (bcd_adj << 1) | BCD_W'(src_q[DATA_W-1]);

        // Any nonzero digit beyond the display width means the number does not fit.
        if (|bcd_step[BCD_W-1:DATA_W]) dec_glyphs = {NDIGITS{SEG_DASH}};
        else                           dec_glyphs = blank_leading(bcd_step[DATA_W-1:0]);
    end

    // FSM next state: conversion stepping, with any load overriding (latest load wins).
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;

        if (state_q == CONV) begin
            src_d = src_q << 1;
            bcd_d = bcd_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                disp_d  = dec_glyphs;
            end
        end

        if (bus.load) begin
            case (bus.mode)
                2'b10: begin
                    state_d = CONV;
                    src_d   = bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
                2'b01: begin
                    state_d = IDLE;
                    disp_d  = lz_glyphs;
                end
                default: begin
                    state_d = IDLE;
                    disp_d  = hex_glyphs;
                end
            endcase
        end
    end

    // Blink timer: free-running half-period counter while enabled, cleared otherwise.
    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (bus.blink_en) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLK_W'(1);
                blink_phase_d = blink_phase_q;
            end
        end
    end

    // State registers; reset blanks the display and abandons any conversion.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q       <= IDLE;
            src_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            disp_q        <= '1;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            disp_q        <= disp_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign bus.busy = (state_q == CONV);
    assign bus.HEX  = blink_phase_q ? '1 : disp_q;

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised seven-segment display controller for the board-level ALU and CPU bring-up tops. It captures a DATA_W-bit value on a load strobe and drives NDIGITS active-low seven-segment digits in one of three modes: raw hex, hex with leading-zero blanking, or unsigned decimal. Decimal mode uses an iterative shift-add-3 (double-dabble) converter with a busy flag. An optional blink timer blanks the whole display periodically.

## Interface
- NDIGITS, 8: number of seven-segment digits driven; DATA_W = 4*NDIGITS (derived, not overridable).
- BLINK_DIV, 25000000: cycles per blink half-period; must be ≥ 2.
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset: one clock, reset is synchronous and active-high.
- load  in  1  capture `value` and `mode` this cycle.
- value  in  DATA_W  number to display.
- mode  in  2  00 hex, 01 hex leading-zero-blanked, 10 unsigned decimal, 11 reserved (treated as 00).
- blink_en  in  1  enable periodic blanking.
- busy  out  1  decimal conversion in progress.
- HEX  out  7*NDIGITS  segments, active-low. Digit i = HEX[7i+6:7i]. Digit 0 is the least significant.

## Operation
- Glyphs (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110
  - blank=1111111, dash=0111111.
- Display register disp holds NDIGITS glyphs.
- HEX = blink_phase ? all blank : disp.
- FSM states:
  - IDLE: busy=0.
  - CONV: busy=1. bcd shift register is 4*(NDIGITS+2) bits wide. Bit counter runs 0..DATA_W-1.
  - IDLE→IDLE on load with mode 00/01/11: disp is written next edge.
  - IDLE→CONV on load with mode 10: latch value into shift source, clear bcd, clear counter.
  - CONV step, one per cycle: every BCD nibble ≥5 gets +3, then the whole register shifts left 1, taking in the next value MSB.
  - CONV→IDLE after DATA_W shifts; disp is written on that same edge.
- Hex mode: digit i = glyph(value[4i+3:4i]).
- Leading-zero-blanked hex: digits above the most significant nonzero nibble are blank. Value 0 shows a single "0" on digit 0.
- Decimal mode:
  - Digits above the most significant nonzero BCD digit are blank. Value 0 shows "0".
  - If any BCD digit at index ≥ NDIGITS is nonzero (value ≥ 10^NDIGITS), every digit shows dash.
- Load during CONV aborts the current conversion. The new load is handled as if from IDLE, so the latest load wins and the aborted result is never displayed.
- load is ignored on cycles where RST=1.
- Blink:
  - While blink_en=1, a counter counts 0..BLINK_DIV-1 and wraps; blink_phase toggles on each wrap.
  - While blink_en=0, the counter and blink_phase clear to 0 on the next edge.
  - The blink timer is independent of the FSM.
- Reset values: state IDLE, busy=0, disp all blank (HEX all 1s), blink counter 0, blink_phase 0.
- RST mid-conversion returns the FSM to IDLE and blanks disp. No partial result is shown.

## Timing
- Hex modes: load sampled at edge N; HEX shows the new value after edge N (1-cycle latency).
- Decimal mode:
  - load at edge N → busy=1 after edge N.
  - busy=0 and HEX updated after edge N+DATA_W (32 cycles for NDIGITS=8).
  - HEX holds its previous content throughout the conversion.
- Blink: with blink_en held high from edge M, the first blank period begins after edge M+BLINK_DIV. Each half-period is exactly BLINK_DIV cycles.
- No combinational path from inputs to HEX or busy. Everything is registered except the blink blanking mux on registered signals.

## Test plan
- Reset then hex: RST high 2 cycles → HEX = all 1s, busy=0. Then load value=0x0000BEEF, mode=00 → next cycle HEX7..HEX4 = 1000000, HEX3 = 0000011, HEX2 = HEX1 = 0000110, HEX0 = 0001110.
- Leading-zero blank: mode=01, value=0x00000A05 → HEX2 = 0001000, HEX1 = 1000000, HEX0 = 0010010, HEX7..HEX3 blank. Then value=0 → only HEX0 = 1000000.
- Decimal and overflow:
  - mode=10, value=12345 → busy high exactly 32 cycles; then HEX4..HEX0 = 1,2,3,4,5 and HEX7..HEX5 blank.
  - value=0xFFFFFFFF → all eight digits dash.
  - value=99999999 → eight 9s (0010000).
- Abort and reset mid-conversion:
  - load 500 (mode 10); at cycle 10 load 0x7 (mode 00) → HEX0 = 1111000 next cycle, busy=0, "500" never appears.
  - Separately, RST at cycle 5 of a conversion → HEX all blank, busy=0.
- Blink (BLINK_DIV=4 in bench): blink_en=1 → HEX alternates 4 cycles visible / 4 cycles blank. Drop blink_en during a blank phase → visible on the next cycle, and disp is unchanged.
